// File: rtl/bus_arb_mux.sv
// bus_arb_mux: N-channel, W-bit registered multiplexer with built-in arbitration.
// The winner is picked by fixed priority (MODE 0) or round-robin (MODE 1). The grant is
// held across multi-beat bursts, and the selected beat is registered so downstream
// timing is decoupled from the sources.
module bus_arb_mux #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MODE     = 0,
  // Derived; do not override.
  parameter int unsigned SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  input  logic [CHANNELS-1:0]          in_valid,
  input  logic [CHANNELS-1:0]          in_last,
  output logic [CHANNELS-1:0]          in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [SELW-1:0]              out_sel,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready
);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e            state_q;
  logic [SELW-1:0]   rr_ptr_q;

  logic [SELW-1:0]   grant;
  logic              grant_ok;
  logic              space;
  logic              in_fire;
  logic [WIDTH-1:0]  sel_data;
  logic              sel_last;
  logic [SELW-1:0]   rr_next;

  assign space = !out_valid || out_ready;

  // Pick the candidate channel: the locked one, or a fresh winner from the valids.
  // While locked, out_sel already holds the channel that opened the burst.
  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    if (state_q == StLocked) begin
      grant    = out_sel;
      grant_ok = 1'b1;
    end else if (MODE == 0) begin
      // Scan downwards so the lowest valid index is the last one written.
      for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant    = SELW'(i);
          grant_ok = 1'b1;
        end
      end
    end else begin
      // Cyclic scan starting at the round-robin pointer; first hit wins.
      for (int k = 0; k < int'(CHANNELS); k++) begin
        if (!grant_ok && in_valid[(int'(rr_ptr_q) + k) % int'(CHANNELS)]) begin
          grant    = SELW'((int'(rr_ptr_q) + k) % int'(CHANNELS));
          grant_ok = 1'b1;
        end
      end
    end
  end

  // Accept a beat only from the granted channel, only when the output can load.
  always_comb begin
    in_ready = '0;
    if (rst_n && space && grant_ok && in_valid[grant]) begin
      in_ready[grant] = 1'b1;
    end
  end

  assign in_fire  = |in_ready;
  assign sel_data = in_data[grant * WIDTH +: WIDTH];
  assign sel_last = in_last[grant];
  assign rr_next  = (grant == SELW'(CHANNELS - 1)) ? '0 : grant + SELW'(1);

  // Arbiter state, round-robin pointer and output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (in_fire) begin
        // A new beat overwrites the register even if the old one leaves this cycle.
        out_data  <= sel_data;
        out_sel   <= grant;
        out_last  <= sel_last;
        out_valid <= 1'b1;
        if (sel_last) begin
          state_q  <= StIdle;
          rr_ptr_q <= rr_next;
        end else begin
          state_q  <= StLocked;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
